play_state_ctrl: RTL and testbench
==================================

Name: play_state_ctrl

Overview:
- Frame-rate game sequencer that drives the color mapper's mode inputs: death, reversal, closePacman, red_enable, green_enable and aqua_enable.
- Also owns the lives count and a position-reset pulse to the pacman/ghost motion blocks.
- Consumes per-frame ticks, collision flags and pickup events from the gameplay logic.
- Sits between the motion/collision blocks and color_mapper, in the Clk domain.

Parameters:
- FRIGHT_FRAMES, 300: frames of frightened mode after a power fruit.
- WARN_FRAMES, 90: final frames of fright during which reversal blinks.
- RESPAWN_FRAMES, 180: frames an eaten ghost stays disabled.
- MOUTH_FRAMES, 8: frames per closePacman toggle.
- DYING_FRAMES, 120: length of the death sequence.
- LIVES, 3: lives loaded at reset and at restart.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-Clk pulse per video frame
- start  in  1  level; begin/resume play
- pac_moving  in  1  level; pacman advanced this frame
- power_eaten  in  1  one-cycle pulse; power fruit collected
- level_clear  in  1  one-cycle pulse; all dots eaten
- hit_red, hit_green, hit_aqua  in  1 each  level; pacman overlaps that ghost
- death  out  1  GAME OVER screen select
- reversal  out  1  frightened-ghost colouring
- closePacman  out  1  mouth-closed sprite select
- red_enable, green_enable, aqua_enable  out  1 each  ghost visible/active
- pos_reset  out  1  one-cycle pulse; return sprites to start positions
- lives  out  2  remaining lives
- state_o  out  3  current state code (debug)

Behaviour:
- All outputs are registered and change one Clk after the causing event.
- Reset values: state READY, death=0, reversal=0, closePacman=0, all enables=1, pos_reset=0, lives=LIVES, all counters=0.
- Counters decrement only on cycles with frame_tick=1. All other inputs are sampled every Clk.
- States:
  - READY: start=1 -> PLAY.
  - PLAY:
    - power_eaten -> FRIGHT, fright_cnt=FRIGHT_FRAMES.
    - Any hit_x with x_enable=1 -> DYING, lives-1, dying_cnt=DYING_FRAMES.
    - Hits on disabled ghosts are ignored.
  - FRIGHT:
    - hit_x with x_enable=1 -> x_enable=0 and that ghost's respawn counter loads RESPAWN_FRAMES. Several ghosts hit in the same cycle are all eaten.
    - power_eaten reloads fright_cnt to FRIGHT_FRAMES.
    - On a tick with fright_cnt==1 -> PLAY, fright_cnt=0.
  - DYING:
    - All enables=0 and closePacman=1.
    - On a tick with dying_cnt==1: if lives==0 -> GAME_OVER; else -> READY with pos_reset pulse and all enables=1.
  - GAME_OVER:
    - death=1.
    - start=1 -> READY, lives=LIVES, enables=1, pos_reset pulse.
- Priorities in PLAY, same cycle: level_clear > power_eaten > hit.
  - level_clear from PLAY or FRIGHT -> READY with pos_reset, fright and respawn counters cleared, enables=1, lives unchanged.
  - power_eaten together with hit_x: enter FRIGHT and eat ghost x in the same cycle; no death.
- reversal:
  - 1 in FRIGHT while fright_cnt > WARN_FRAMES.
  - 1 in FRIGHT while fright_cnt ≤ WARN_FRAMES and fright_cnt[3]=1.
  - 0 in every other state.
- Respawn counters run in PLAY and FRIGHT only and freeze in READY. On a tick with respawn counter==1: counter=0, enable=1.
- closePacman:
  - In PLAY/FRIGHT with pac_moving=1, mouth_cnt counts ticks and closePacman toggles when mouth_cnt reaches MOUTH_FRAMES-1; mouth_cnt then wraps to 0.
  - With pac_moving=0, closePacman holds its value.
  - In READY, closePacman=0 and mouth_cnt=0.
- lives saturates at 0 and never underflows.
- pos_reset is high for exactly one Clk.
- Reset asserted mid-sequence forces the reset values immediately (asynchronous).
- Counter widths are $clog2(param+1); all compares are unsigned.

Decomposition:
- Shared package play_pkg:
  - state enum: READY=0, PLAY=1, FRIGHT=2, DYING=3, GAME_OVER=4.
  - ghost index constants: RED=0, GREEN=1, AQUA=2.
- One sub-module, ghost_respawn_timer, instantiated three times:
  - Inputs: load, run, frame_tick, clear.
  - Output: enable.
  - Parameter: RESPAWN_FRAMES.

Test Plan:
- Bench parameters: FRIGHT=20, WARN=8, RESPAWN=6, MOUTH=2, DYING=4, LIVES=2.
- Reset, then start=1 -> state_o=1, enables=111, reversal=0, lives=2.
- In PLAY, hit_red=1 -> next Clk state_o=3, lives=1, enables=000. After 4 ticks -> state_o=0, one-Clk pos_reset, enables=111.
- power_eaten, then hit_green on the same cycle -> state_o=2, green_enable=0, reversal=1. After 6 ticks green_enable=1. reversal follows fright_cnt[3] from count 8 down. After 20 ticks -> PLAY.
- FRIGHT with hit_red and hit_aqua simultaneous -> both enables 0, no death, lives unchanged.
- Two deaths from LIVES=2 -> GAME_OVER, death=1. start -> READY, lives=2, pos_reset pulse.
- pac_moving=1 for 6 ticks -> closePacman toggles every 2 ticks (0,1,0,1 pattern). Assert Reset mid-FRIGHT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/play_pkg.sv
// Shared types for the play-state sequencer: state encoding and ghost indices.
package play_pkg;

  typedef enum logic [2:0] {
    READY     = 3'd0,
    PLAY      = 3'd1,
    FRIGHT    = 3'd2,
    DYING     = 3'd3,
    GAME_OVER = 3'd4
  } state_e;

  localparam int RED        = 0;
  localparam int GREEN      = 1;
  localparam int AQUA       = 2;
  localparam int NUM_GHOSTS = 3;

endpackage

// File: rtl/ghost_respawn_timer.sv
// Per-ghost visibility flag with a frame-based respawn countdown after being eaten.
module ghost_respawn_timer #(
  parameter int RESPAWN_FRAMES = 180
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  input  logic run,
  input  logic frame_tick,
  input  logic clear,
  output logic enable
);

  localparam int CW = $clog2(RESPAWN_FRAMES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          enable_q, enable_d;

  always_comb begin
    // NOTE: every variable gets a hold value first so no path leaves it unassigned (no latch).
    cnt_d    = cnt_q;
    enable_d = enable_q;
    if (clear) begin
      cnt_d    = '0;
      enable_d = 1'b1;
    end else if (load) begin
      cnt_d    = CW'(RESPAWN_FRAMES);
      enable_d = 1'b0;
    end else if (run && frame_tick && (cnt_q != '0)) begin
      if (cnt_q == CW'(1)) begin
        cnt_d    = '0;
        enable_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q    <= '0;
      enable_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
    end
  end

  assign enable = enable_q;

endmodule

// File: rtl/play_state_ctrl.sv
// Frame-rate game sequencer: play/fright/dying/game-over states, lives, mouth
// animation and the colour-mapper mode bits.
module play_state_ctrl
  import play_pkg::*;
#(
  parameter int FRIGHT_FRAMES  = 300,
  parameter int WARN_FRAMES    = 90,
  parameter int RESPAWN_FRAMES = 180,
  parameter int MOUTH_FRAMES   = 8,
  parameter int DYING_FRAMES   = 120,
  parameter int LIVES          = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pac_moving,
  input  logic       power_eaten,
  input  logic       level_clear,
  input  logic       hit_red,
  input  logic       hit_green,
  input  logic       hit_aqua,
  output logic       death,
  output logic       reversal,
  output logic       closePacman,
  output logic       red_enable,
  output logic       green_enable,
  output logic       aqua_enable,
  output logic       pos_reset,
  output logic [1:0] lives,
  output logic [2:0] state_o
);

  localparam int FW = $clog2(FRIGHT_FRAMES + 1);
  localparam int DW = $clog2(DYING_FRAMES + 1);
  localparam int MW = $clog2(MOUTH_FRAMES + 1);

  state_e          state_q, state_d;
  logic [FW-1:0]   fright_cnt_q, fright_cnt_d;
  logic [DW-1:0]   dying_cnt_q, dying_cnt_d;
  logic [MW-1:0]   mouth_cnt_q, mouth_cnt_d;
  logic [1:0]      lives_q, lives_d;
  logic            death_q, death_d;
  logic            reversal_q, reversal_d;
  logic            close_q, close_d;
  logic            pos_reset_q, pos_reset_d;

  logic [NUM_GHOSTS-1:0] en_v, hit_v, load_v;
  logic                  clear_all, run;

  assign hit_v = {hit_aqua, hit_green, hit_red} & en_v;
  assign run   = (state_q == PLAY) || (state_q == FRIGHT);

  always_comb begin
    state_d      = state_q;
    fright_cnt_d = fright_cnt_q;
    dying_cnt_d  = dying_cnt_q;
    lives_d      = lives_q;
    pos_reset_d  = 1'b0;
    load_v       = '0;
    clear_all    = 1'b0;

    unique case (state_q)
      READY: if (start) state_d = PLAY;
      PLAY, FRIGHT: begin
        if (level_clear) begin
          state_d      = READY;
          pos_reset_d  = 1'b1;
          clear_all    = 1'b1;
          fright_cnt_d = '0;
        end else if (state_q == FRIGHT || power_eaten) begin
          // Any power pickup makes contact with live ghosts safe this very cycle.
          load_v = hit_v;
          if (power_eaten) begin
            state_d      = FRIGHT;
            fright_cnt_d = FW'(FRIGHT_FRAMES);
          end else if (frame_tick) begin
            if (fright_cnt_q == FW'(1)) begin
              state_d      = PLAY;
              fright_cnt_d = '0;
            end else if (fright_cnt_q != '0) begin
              fright_cnt_d = fright_cnt_q - FW'(1);
            end
          end
        end else if (|hit_v) begin
          state_d     = DYING;
          lives_d     = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          dying_cnt_d = DW'(DYING_FRAMES);
          load_v      = '1;
        end
      end
      DYING: if (frame_tick) begin
        if (dying_cnt_q == DW'(1)) begin
          dying_cnt_d = '0;
          if (lives_q == 2'd0) begin
            state_d = GAME_OVER;
          end else begin
            state_d     = READY;
            pos_reset_d = 1'b1;
            clear_all   = 1'b1;
          end
        end else if (dying_cnt_q != '0) begin
          dying_cnt_d = dying_cnt_q - DW'(1);
        end
      end
      GAME_OVER: if (start) begin
        state_d     = READY;
        lives_d     = 2'(LIVES);
        pos_reset_d = 1'b1;
        clear_all   = 1'b1;
      end
      default: state_d = READY;
    endcase
  end

  // Output bits are computed from the next state so they line up with state_o.
  always_comb begin
    mouth_cnt_d = mouth_cnt_q;
    close_d     = close_q;
    death_d     = (state_d == GAME_OVER);
    reversal_d  = (state_d == FRIGHT) &&
                  ((fright_cnt_d > FW'(WARN_FRAMES)) || (|(fright_cnt_d & FW'(8))));
    if (state_d == READY) begin
      mouth_cnt_d = '0;
      close_d     = 1'b0;
    end else if (state_d == DYING) begin
      close_d = 1'b1;
    end else if ((state_d == PLAY || state_d == FRIGHT) && pac_moving && frame_tick) begin
      if (mouth_cnt_q == MW'(MOUTH_FRAMES - 1)) begin
        mouth_cnt_d = '0;
        close_d     = ~close_q;
      end else begin
        mouth_cnt_d = mouth_cnt_q + MW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= READY;
      fright_cnt_q <= '0;
      dying_cnt_q  <= '0;
      mouth_cnt_q  <= '0;
      lives_q      <= 2'(LIVES);
      death_q      <= 1'b0;
      reversal_q   <= 1'b0;
      close_q      <= 1'b0;
      pos_reset_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fright_cnt_q <= fright_cnt_d;
      dying_cnt_q  <= dying_cnt_d;
      mouth_cnt_q  <= mouth_cnt_d;
      lives_q      <= lives_d;
      death_q      <= death_d;
      reversal_q   <= reversal_d;
      close_q      <= close_d;
      pos_reset_q  <= pos_reset_d;
    end
  end

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
    ghost_respawn_timer #(
      .RESPAWN_FRAMES(RESPAWN_FRAMES)
    ) u_timer (
      .Clk       (Clk),
      .Reset     (Reset),
      .load      (load_v[g]),
      .run       (run),
      .frame_tick(frame_tick),
      .clear     (clear_all),
      .enable    (en_v[g])
    );
  end

  assign red_enable   = en_v[RED];
  assign green_enable = en_v[GREEN];
  assign aqua_enable  = en_v[AQUA];
  assign death        = death_q;
  assign reversal     = reversal_q;
  assign closePacman  = close_q;
  assign pos_reset    = pos_reset_q;
  assign lives        = lives_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_play_state_ctrl.sv
// Directed bench for play_state_ctrl with short frame counts.
module tb_play_state_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0, start = 1'b0, pac_moving = 1'b0;
  logic       power_eaten = 1'b0, level_clear = 1'b0;
  logic       hit_red = 1'b0, hit_green = 1'b0, hit_aqua = 1'b0;
  logic       death, reversal, closePacman;
  logic       red_enable, green_enable, aqua_enable, pos_reset;
  logic [1:0] lives;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  play_state_ctrl #(
    .FRIGHT_FRAMES (20),
    .WARN_FRAMES   (8),
    .RESPAWN_FRAMES(6),
    .MOUTH_FRAMES  (2),
    .DYING_FRAMES  (4),
    .LIVES         (2)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .start       (start),
    .pac_moving  (pac_moving),
    .power_eaten (power_eaten),
    .level_clear (level_clear),
    .hit_red     (hit_red),
    .hit_green   (hit_green),
    .hit_aqua    (hit_aqua),
    .death       (death),
    .reversal    (reversal),
    .closePacman (closePacman),
    .red_enable  (red_enable),
    .green_enable(green_enable),
    .aqua_enable (aqua_enable),
    .pos_reset   (pos_reset),
    .lives       (lives),
    .state_o     (state_o)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
    end
  endtask

  function automatic int en3();
    return int'({aqua_enable, green_enable, red_enable});
  endfunction

  initial begin
    // Reset values while Reset is held.
    repeat (2) @(posedge Clk);
    #1;
    check("rst_state", state_o, 0);
    check("rst_en", en3(), 7);
    check("rst_lives", lives, 2);
    check("rst_rev", reversal, 0);
    check("rst_death", death, 0);
    check("rst_close", closePacman, 0);
    check("rst_posrst", pos_reset, 0);
    Reset = 1'b0;
    cycle();

    // READY -> PLAY
    start = 1'b1; cycle(); start = 1'b0;
    check("start_state", state_o, 1);
    check("start_en", en3(), 7);
    check("start_rev", reversal, 0);
    check("start_lives", lives, 2);

    // First death
    hit_red = 1'b1; cycle(); hit_red = 1'b0;
    check("die_state", state_o, 3);
    check("die_lives", lives, 1);
    check("die_en", en3(), 0);
    check("die_close", closePacman, 1);
    ticks(3);
    check("dying3_state", state_o, 3);
    ticks(1);
    check("respawn_state", state_o, 0);
    check("respawn_posrst", pos_reset, 1);
    check("respawn_en", en3(), 7);
    check("respawn_close", closePacman, 0);
    cycle();
    check("posrst_one_clk", pos_reset, 0);

    // power_eaten with hit_green in the same cycle
    start = 1'b1; cycle(); start = 1'b0;
    power_eaten = 1'b1; hit_green = 1'b1; cycle();
    power_eaten = 1'b0; hit_green = 1'b0;
    check("fr_state", state_o, 2);
    check("fr_en", en3(), 3'b101);
    check("fr_rev", reversal, 1);
    check("fr_lives", lives, 1);
    ticks(5);
    check("green_t5", green_enable, 0);
    ticks(1);
    check("green_t6", green_enable, 1);
    ticks(5);
    check("rev_cnt9", reversal, 1);
    ticks(1);
    check("rev_cnt8", reversal, 1);
    ticks(1);
    check("rev_cnt7", reversal, 0);
    ticks(6);
    check("fr_cnt1_state", state_o, 2);
    ticks(1);
    check("fr_end_state", state_o, 1);
    check("fr_end_rev", reversal, 0);

    // Two ghosts eaten together in FRIGHT
    power_eaten = 1'b1; cycle(); power_eaten = 1'b0;
    check("fr2_en", en3(), 7);
    hit_red = 1'b1; hit_aqua = 1'b1; cycle();
    hit_red = 1'b0; hit_aqua = 1'b0;
    check("eat2_en", en3(), 3'b010);
    check("eat2_state", state_o, 2);
    check("eat2_lives", lives, 1);

    // level_clear from FRIGHT
    level_clear = 1'b1; cycle(); level_clear = 1'b0;
    check("lc_state", state_o, 0);
    check("lc_posrst", pos_reset, 1);
    check("lc_en", en3(), 7);
    check("lc_lives", lives, 1);
    check("lc_rev", reversal, 0);

    // Mouth animation
    start = 1'b1; cycle(); start = 1'b0;
    pac_moving = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      ticks(1);
      check($sformatf("mouth_t%0d", k), closePacman, (k / 2) % 2);
    end
    pac_moving = 1'b0;
    ticks(2);
    check("mouth_hold", closePacman, 1);

    // Second death -> GAME_OVER -> restart
    hit_aqua = 1'b1; cycle(); hit_aqua = 1'b0;
    check("die2_state", state_o, 3);
    check("die2_lives", lives, 0);
    ticks(4);
    check("go_state", state_o, 4);
    check("go_death", death, 1);
    check("go_posrst", pos_reset, 0);
    check("go_en", en3(), 0);
    start = 1'b1; cycle(); start = 1'b0;
    check("restart_state", state_o, 0);
    check("restart_lives", lives, 2);
    check("restart_posrst", pos_reset, 1);
    check("restart_death", death, 0);
    check("restart_en", en3(), 7);

    // Asynchronous reset in the middle of FRIGHT
    start = 1'b1; cycle(); start = 1'b0;
    power_eaten = 1'b1; hit_green = 1'b1; cycle();
    power_eaten = 1'b0; hit_green = 1'b0;
    check("fr3_state", state_o, 2);
    ticks(2);
    #2;
    Reset = 1'b1;
    #1;
    check("arst_state", state_o, 0);
    check("arst_en", en3(), 7);
    check("arst_rev", reversal, 0);
    check("arst_lives", lives, 2);
    check("arst_close", closePacman, 0);
    check("arst_posrst", pos_reset, 0);
    Reset = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
